mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares the single-port unified memory between instruction fetch (IF, read-only) and the MEM stage data path, which is driven by the decoded `mem_read`/`mem_write` controls. Grants one requester at a time and runs a req/ready handshake to memory with variable latency. Returns read data and a one-cycle acknowledge to the winner. Raises `stall` to the pipeline while any request is outstanding.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants tolerated while IF waits (guard build only); must be ≥1

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word, valid while `if_ack`
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `d_read`  in  1  load request (from `mem_read`)
- `d_write`  in  1  store request (from `mem_write`)
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`
- `d_ack`  out  1  one-cycle completion pulse for data
- `m_req`  out  1  memory request, held until `m_ready`
- `m_we`  out  1  memory write enable
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data, valid with `m_ready`
- `m_ready`  in  1  memory completion
- `stall`  out  1  pipeline hold

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: if `d_read|d_write` → BUSY_D; else if `if_req` → BUSY_I; else stay. Data has fixed priority, except when the starvation guard overrides it (see Configuration).
- On grant, register `m_addr`, `m_we`, and `m_wdata` from the winner and set `m_req`=1.
- Store: `m_we`=1.
- Load and fetch: `m_we`=0, `m_wdata`=0.
- If `d_read` and `d_write` are both high, the request is treated as a store.
- BUSY_x: hold `m_req` and all `m_*` outputs stable until `m_ready` is sampled high.
  - Store completion: → DONE, pulse `d_ack`; `d_rdata` unchanged.
  - Load completion: → DONE, capture `m_rdata` into `d_rdata`, pulse `d_ack`.
  - Fetch completion: → DONE, capture `m_rdata` into `if_rdata`, pulse `if_ack`.
- DONE: `m_req`=0, no arbitration; → IDLE next cycle. This gives requesters one cycle to drop or change the request after ack.
- Request inputs that change during BUSY are ignored; the latched values are used.
- `m_ready` is ignored in IDLE and DONE.
- `stall` = ((`d_read`|`d_write`) & ~`d_ack`) | (`if_req` & ~`if_ack`); combinational.
- `if_rdata` and `d_rdata` hold their last captured value between transactions.

## Timing
- Reset (async assert, sync release): state IDLE. `m_req`, `m_we`, `m_addr`, `m_wdata`, `if_ack`, `d_ack`, `if_rdata`, `d_rdata` all 0. Starvation counter 0.
- Reset mid-transaction: the transaction is abandoned and `m_req` falls immediately, with no ack.
- Latency:
  - Request visible in IDLE at cycle 0 → `m_req` high at cycle 1.
  - With `m_ready` high at cycle 1, ack is high at cycle 2.
  - Next arbitration happens at cycle 3.
  - Each extra `m_ready`-low cycle adds one cycle.
- Throughput: at most one transaction per 3 cycles.
- Both requesters arriving in the same cycle: data wins; IF is served next, after DONE.
- `if_ack` and `d_ack` are never high in the same cycle.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each data grant issued while `if_req` is high.
  - The counter clears on any IF grant, or in IDLE when `if_req` is low.
  - In IDLE with counter == `STARVE_MAX` and `if_req` high, IF is granted even if data is requesting.
- `ARB_STARVE_GUARD_EN` undefined: strict data priority and no counter logic. IF can starve indefinitely.

## Test plan
- Reset state: assert `rst_n`=0 with requests active → all outputs 0 and state IDLE. Release, drive `if_req`=1, `if_addr`=0x100, `m_ready`=1 constant, `m_rdata`=0x00000013 → `m_req`=1 with `m_addr`=0x100 and `m_we`=0 at cycle 1; `if_ack`=1 with `if_rdata`=0x13 at cycle 2.
- Store then load:
  - `d_write`, `d_addr`=0x40, `d_wdata`=0xDEADBEEF → `m_we`=1, `m_wdata`=0xDEADBEEF; `d_ack` pulses; `d_rdata` unchanged.
  - Then `d_read` at 0x40 with `m_rdata`=0xDEADBEEF → `d_rdata`=0xDEADBEEF.
- Collision: `if_req` and `d_read` rise in the same cycle → data transaction first, IF second. `stall`=1 throughout until `if_ack`.
- Wait states: `m_ready` low for 5 cycles → `m_req` and `m_addr` stable for 6 cycles; ack 1 cycle after `m_ready`. An `m_ready` pulse while IDLE → no ack.
- Reset mid-BUSY_D: `rst_n` low while `m_ready`=0 → `m_req` drops asynchronously and no `d_ack` pulses.
- Guard (`ARB_STARVE_GUARD_EN`, `STARVE_MAX`=4): continuous `d_read` plus `if_req` → 4 data grants, then 1 IF grant, then data resumes. Without the macro, IF is never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the MEM-stage data path.
// Optional IF starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t              state, state_nx;
  logic                m_req_nx, m_we_nx, if_ack_nx, d_ack_nx;
  logic [ADDR_W-1:0]   m_addr_nx;
  logic [DATA_W-1:0]   m_wdata_nx, if_rdata_nx, d_rdata_nx;
  logic                d_any;
  logic                force_if;

  if (STARVE_MAX < 1) begin : g_starve_max_check
    $error("STARVE_MAX must be at least 1");
  end

  assign d_any = d_read | d_write;
  assign stall = (d_any & ~d_ack) | (if_req & ~if_ack);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt, starve_cnt_nx;

  assign force_if = (starve_cnt == CNT_W'(STARVE_MAX)) && if_req;

  // Counts data grants that bypass a waiting fetch; any IF grant or idle fetch clears it.
  always_comb begin
    starve_cnt_nx = starve_cnt;
    if (state == IDLE) begin
      if (!if_req)
        starve_cnt_nx = '0;
      else if (d_any && !force_if)
        starve_cnt_nx = starve_cnt + CNT_W'(1);
      else
        starve_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt_nx;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    m_req_nx    = m_req;
    m_we_nx     = m_we;
    m_addr_nx   = m_addr;
    m_wdata_nx  = m_wdata;
    if_rdata_nx = if_rdata;
    d_rdata_nx  = d_rdata;
    if_ack_nx   = 1'b0;
    d_ack_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (d_any && !force_if) begin
          state_nx   = BUSY_D;
          m_req_nx   = 1'b1;
          m_addr_nx  = d_addr;
          m_we_nx    = d_write;
          m_wdata_nx = d_write ? d_wdata : '0;
        end else if (if_req) begin
          state_nx   = BUSY_I;
          m_req_nx   = 1'b1;
          m_addr_nx  = if_addr;
          m_we_nx    = 1'b0;
          m_wdata_nx = '0;
        end
      end
      BUSY_I: begin
        if (m_ready) begin
          state_nx    = DONE;
          m_req_nx    = 1'b0;
          if_ack_nx   = 1'b1;
          if_rdata_nx = m_rdata;
        end
      end
      BUSY_D: begin
        if (m_ready) begin
          state_nx = DONE;
          m_req_nx = 1'b0;
          d_ack_nx = 1'b1;
          if (!m_we)
            d_rdata_nx = m_rdata;
        end
      end
      DONE: begin
        state_nx = IDLE;
        m_req_nx = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        m_req_nx = 1'b0;
      end
    endcase
  end

  // Reset abandons any transaction in flight, so m_req drops without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
    end else begin
      state    <= state_nx;
      m_req    <= m_req_nx;
      m_we     <= m_we_nx;
      m_addr   <= m_addr_nx;
      m_wdata  <= m_wdata_nx;
      if_rdata <= if_rdata_nx;
      d_rdata  <= d_rdata_nx;
      if_ack   <= if_ack_nx;
      d_ack    <= d_ack_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps then random traffic against a
// transaction-level model of requesters, arbitration policy and memory contents.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_read, d_write, m_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] if_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          if_ack, d_ack, m_req, m_we, stall;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester model: a pending request is held until the arbiter acknowledges it.
  bit            if_pend, d_pend, d_is_wr, d_both;
  logic [AW-1:0] if_a, d_a;
  logic [DW-1:0] d_wd, fetch_data, exp_if_rdata, exp_d_rdata;
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            starve;
  bit            won;

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_value(input logic [AW-1:0] a);
    if (mem.exists(a))
      return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic drive_inputs();
    if_req  = if_pend;
    if_addr = if_a;
    d_write = d_pend && d_is_wr;
    d_read  = d_pend && (!d_is_wr || d_both);
    d_addr  = d_a;
    d_wdata = d_wd;
  endtask

  // One full arbitration round, entered and left at a falling edge with the DUT idle.
  task automatic apply_stimulus(input int waits, output bit won_if);
    bit            force_if;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd, rd;
    check_flag("idle_m_req", m_req, 1'b0);
    check_flag("idle_if_ack", if_ack, 1'b0);
    check_flag("idle_d_ack", d_ack, 1'b0);
    drive_inputs();
    m_ready = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    #1;
    check_flag("idle_stall", stall, d_pend | if_pend);

    force_if = GUARD && (starve == SMAX) && if_pend;
    won_if   = !(d_pend && !force_if);
    if (won_if)       starve = 0;
    else if (if_pend) starve = starve + 1;
    else              starve = 0;
    ea  = won_if ? if_a : d_a;
    ewe = !won_if && d_is_wr;
    ewd = ewe ? d_wd : '0;

    @(posedge clk); @(negedge clk);
    check_flag("grant_m_req", m_req, 1'b1);
    check_output("grant_m_addr", m_addr, ea);
    check_flag("grant_m_we", m_we, ewe);
    check_output("grant_m_wdata", m_wdata, ewd);
    check_flag("grant_stall", stall, d_pend | if_pend);
    if_addr = $urandom;
    d_addr  = $urandom;
    d_wdata = $urandom;

    for (int i = 0; i < waits; i++) begin
      m_ready = 1'b0;
      m_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      check_flag("wait_m_req", m_req, 1'b1);
      check_output("wait_m_addr", m_addr, ea);
      check_output("wait_m_wdata", m_wdata, ewd);
      check_flag("wait_ack", if_ack | d_ack, 1'b0);
    end

    m_ready = 1'b1;
    if (won_if)       rd = fetch_data;
    else if (d_is_wr) rd = $urandom;
    else              rd = mem_value(d_a);
    m_rdata = rd;
    @(posedge clk); @(negedge clk);
    if (won_if)       exp_if_rdata = rd;
    else if (d_is_wr) mem[d_a] = d_wd;
    else              exp_d_rdata = rd;
    check_flag("done_if_ack", if_ack, won_if);
    check_flag("done_d_ack", d_ack, !won_if);
    check_flag("done_m_req", m_req, 1'b0);
    check_output("done_if_rdata", if_rdata, exp_if_rdata);
    check_output("done_d_rdata", d_rdata, exp_d_rdata);
    check_flag("done_stall", stall, (d_pend && won_if) || (if_pend && !won_if));

    if (won_if) if_pend = 1'b0;
    else        d_pend  = 1'b0;
    drive_inputs();
    m_ready = 1'($urandom_range(0, 1));
    @(posedge clk); @(negedge clk);
    check_flag("after_ack", if_ack | d_ack, 1'b0);
    check_flag("after_stall", stall, d_pend | if_pend);
  endtask

  initial begin
    rst_n   = 1'b0;
    if_req  = 1'b1; if_addr = 32'h0000_0100;
    d_read  = 1'b1; d_write = 1'b0; d_addr = 32'h40; d_wdata = 32'h1111_2222;
    m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
    if_pend = 0; d_pend = 0; d_is_wr = 0; d_both = 0;
    if_a = '0; d_a = '0; d_wd = '0; fetch_data = '0;
    exp_if_rdata = '0; exp_d_rdata = '0; starve = 0;

    repeat (3) @(negedge clk);
    check_flag("rst_m_req", m_req, 1'b0);
    check_flag("rst_m_we", m_we, 1'b0);
    check_output("rst_m_addr", m_addr, '0);
    check_output("rst_m_wdata", m_wdata, '0);
    check_flag("rst_if_ack", if_ack, 1'b0);
    check_flag("rst_d_ack", d_ack, 1'b0);
    check_output("rst_if_rdata", if_rdata, '0);
    check_output("rst_d_rdata", d_rdata, '0);

    rst_n = 1'b1;
    if_pend = 1; if_a = 32'h100; fetch_data = 32'h0000_0013;
    apply_stimulus(0, won);

    d_pend = 1; d_is_wr = 1; d_both = 0; d_a = 32'h40; d_wd = 32'hDEAD_BEEF;
    apply_stimulus(0, won);
    d_pend = 1; d_is_wr = 0; d_a = 32'h40;
    apply_stimulus(0, won);

    if_pend = 1; if_a = 32'h200; fetch_data = 32'h0000_0093;
    d_pend = 1; d_is_wr = 0; d_a = 32'h40;
    apply_stimulus(1, won);
    apply_stimulus(2, won);

    if_pend = 1; if_a = 32'h300; fetch_data = $urandom;
    for (int i = 0; i < 6; i++) begin
      d_pend = 1; d_is_wr = 0; d_a = 32'h50 + 32'(4 * i);
      apply_stimulus(0, won);
    end
    d_pend = 0;
    if (if_pend) apply_stimulus(0, won);

    d_pend = 1; d_is_wr = 1; d_both = 1; d_a = 32'h44; d_wd = 32'h1234_5678;
    apply_stimulus(5, won);
    d_pend = 1; d_is_wr = 0; d_both = 0; d_a = 32'h44;
    apply_stimulus(0, won);

    drive_inputs();
    m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check_flag("idle_pulse_ack", if_ack | d_ack, 1'b0);
      check_flag("idle_pulse_m_req", m_req, 1'b0);
      check_flag("idle_pulse_stall", stall, 1'b0);
    end
    m_ready = 1'b0;

    d_pend = 1; d_is_wr = 0; d_a = 32'h48;
    drive_inputs();
    @(posedge clk); @(negedge clk);
    check_flag("midrst_m_req_before", m_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_flag("midrst_m_req_async", m_req, 1'b0);
    check_flag("midrst_d_ack", d_ack, 1'b0);
    @(negedge clk);
    check_flag("midrst_d_ack_later", d_ack, 1'b0);
    check_output("midrst_d_rdata", d_rdata, '0);
    d_pend = 0; if_pend = 0;
    drive_inputs();
    starve = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 200; t++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1;
        if_a = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      end
      if (!d_pend && $urandom_range(0, 9) < 6) begin
        d_pend = 1;
        d_is_wr = 1'($urandom_range(0, 1));
        d_both = d_is_wr && ($urandom_range(0, 3) == 0);
        d_a = 32'(4 * $urandom_range(0, 15));
        d_wd = $urandom;
      end
      if (!if_pend && !d_pend) begin
        d_pend = 1; d_is_wr = 0; d_both = 0;
        d_a = 32'(4 * $urandom_range(0, 15));
      end
      fetch_data = $urandom;
      apply_stimulus($urandom_range(0, 3), won);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
